// File: rtl/fetch_unit_if.sv
// Instruction ROM bus between the fetch stage and the asynchronous-read ROM.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  // Fetch side drives the address and consumes the same-cycle read data.
  modport master (output imem_addr, input imem_rdata);
  // ROM side returns data combinationally for the presented address.
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the multicycle MIPS core: PC/IR registers,
// next-PC selection, retired-instruction counter and sticky jr alignment flag.
// Optional feature macro: FETCH_BGEZAL_EN (branch select also resolves bgezal).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_wr,
  input  logic             ir_wr,
  input  logic [1:0]       npc_sel,
  input  logic             zero,
  input  logic [31:0]      rs_data,
  fetch_unit_if.master     imem,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      ir,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm16,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             addr_err
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef FETCH_BGEZAL_EN
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;
`endif

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  logic        br_cond;
  logic [31:0] br_off;
  logic [31:0] npc;

  // IR field decode feeding the controller and datapath.
  always_comb begin
    opcode = ir[31:26];
    rs     = ir[25:21];
    rt     = ir[20:16];
    rd     = ir[15:11];
    imm16  = ir[15:0];
    funct  = ir[5:0];
  end

  // Link value and word-scaled, sign-extended branch displacement.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
  end

  // Branch condition for the instruction currently held in IR.
  always_comb begin
    br_cond = 1'b0;
    if (opcode == OP_BEQ) begin
      br_cond = zero;
    end
`ifdef FETCH_BGEZAL_EN
    else if (opcode == OP_REGIMM && rt == RT_BGEZAL) begin
      br_cond = ~rs_data[31];
    end
`endif
  end

  // Next-PC select; jr target always has its low two bits cleared.
  always_comb begin
    npc = pc_plus4;
    case (npc_sel)
      SEL_SEQ: npc = pc_plus4;
      SEL_BR:  npc = br_cond ? (pc_plus4 + br_off) : pc_plus4;
      SEL_J:   npc = {pc_plus4[31:28], ir[25:0], 2'b00};
      SEL_JR:  npc = {rs_data[31:2], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

  // Fetch from the new PC when it updates so PC and IR stay paired.
  always_comb begin
    imem.imem_addr = pc_wr ? npc : pc;
  end

  // PC, retired-instruction counter and sticky misaligned-jr flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr_cnt <= '0;
      addr_err  <= 1'b0;
    end else if (pc_wr) begin
      pc        <= npc;
      instr_cnt <= instr_cnt + CNT_W'(1);
      if (npc_sel == SEL_JR && rs_data[1:0] != 2'b00) begin
        addr_err <= 1'b1;
      end
    end
  end

  // Instruction register; reset value is the sll nop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (ir_wr) begin
      ir <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a transaction-level PC/IR model.
module tb_fetch_unit;

`ifdef FETCH_BGEZAL_EN
  localparam bit BGEZAL_EN = 1'b1;
`else
  localparam bit BGEZAL_EN = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_wr = 1'b0;
  logic        ir_wr = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        zero = 1'b0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] pc, pc_plus4, ir;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] instr_cnt;
  logic        addr_err;

  fetch_unit_if imem_bus();

  fetch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_sel(npc_sel),
    .zero(zero), .rs_data(rs_data), .imem(imem_bus), .pc(pc), .pc_plus4(pc_plus4),
    .ir(ir), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .instr_cnt(instr_cnt), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // ROM: address hash, optionally overridden by a forced instruction word.
  logic        force_en = 1'b0;
  logic [31:0] force_word = 32'h0;

  function automatic logic [31:0] rom_hash(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    return force_en ? force_word : rom_hash(a);
  endfunction

  always_comb imem_bus.imem_rdata = rom_rd(imem_bus.imem_addr);

  // Counters and cycle stamp.
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model state.
  logic [31:0] m_pc, m_ir, m_cnt;
  logic        m_err;

  function automatic void model_reset();
    m_pc = RST_PC; m_ir = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
  endfunction

  function automatic logic [31:0] model_npc(input logic [1:0] sel, input logic z, input logic [31:0] rsd);
    logic [31:0] seq, off;
    logic        take;
    int unsigned op, rtf;
    seq  = m_pc + 32'd4;
    op   = m_ir >> 26;
    rtf  = (m_ir >> 16) & 32'h1F;
    off  = {{16{m_ir[15]}}, m_ir[15:0]} * 32'd4;
    take = 1'b0;
    if (op == 4) take = z;
    else if (BGEZAL_EN && op == 1 && rtf == 17) take = (rsd < 32'h8000_0000);
    case (sel)
      2'd0:    return seq;
      2'd1:    return take ? seq + off : seq;
      2'd2:    return (seq & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
      default: return rsd & ~32'd3;
    endcase
  endfunction

  typedef struct { int unsigned due; logic [31:0] addr, pc4, irv; } comb_t;
  typedef struct { int unsigned due; logic [31:0] pcv, irv, cnt; logic err; } state_t;
  comb_t  comb_q[$];
  state_t state_q[$];

  // Monitor: compare whatever expectations fall due at this sampling point.
  always @(negedge clk) begin : mon
    comb_t  ci;
    state_t si;
    while (comb_q.size() > 0 && comb_q[0].due <= cyc) begin
      ci = comb_q.pop_front();
      if (ci.due != cyc) chk("comb_stale", 64'(ci.due), 64'(cyc));
      else begin
        chk("imem_addr", 64'(imem_bus.imem_addr), 64'(ci.addr));
        chk("pc_plus4", 64'(pc_plus4), 64'(ci.pc4));
        chk("fields", {opcode, rs, rt, rd, imm16, funct},
            64'({6'(ci.irv >> 26), 5'(ci.irv >> 21), 5'(ci.irv >> 16),
                 5'(ci.irv >> 11), 16'(ci.irv), 6'(ci.irv)}));
      end
    end
    while (state_q.size() > 0 && state_q[0].due <= cyc) begin
      si = state_q.pop_front();
      if (si.due != cyc) chk("state_stale", 64'(si.due), 64'(cyc));
      else begin
        chk("pc", 64'(pc), 64'(si.pcv));
        chk("ir", 64'(ir), 64'(si.irv));
        chk("instr_cnt", 64'(instr_cnt), 64'(si.cnt));
        chk("addr_err", 64'(addr_err), 64'(si.err));
      end
    end
  end

  // One controller cycle: drive inputs, advance the model, queue expectations.
  task automatic step(input bit pw, input bit iw, input logic [1:0] sel, input logic z,
                      input logic [31:0] rsd, input bit fe, input logic [31:0] fw);
    logic [31:0] npc, addr;
    comb_t  ci;
    state_t si;
    @(posedge clk); #1;
    force_en = fe; force_word = fw;
    pc_wr = pw; ir_wr = iw; npc_sel = sel; zero = z; rs_data = rsd;
    npc  = model_npc(sel, z, rsd);
    addr = pw ? npc : m_pc;
    ci.due = cyc; ci.addr = addr; ci.pc4 = m_pc + 32'd4; ci.irv = m_ir;
    comb_q.push_back(ci);
    if (iw) m_ir = rom_rd(addr);
    if (pw) begin
      m_pc  = npc;
      m_cnt = m_cnt + 32'd1;
      if (sel == 2'd3 && (rsd % 4) != 0) m_err = 1'b1;
    end
    si.due = cyc + 1; si.pcv = m_pc; si.irv = m_ir; si.cnt = m_cnt; si.err = m_err;
    state_q.push_back(si);
  endtask

  task automatic seq_step();  step(1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0); endtask
  task automatic load(input logic [31:0] w); step(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 1'b1, w); endtask
  task automatic jump_reg(input logic [31:0] t); step(1'b1, 1'b0, 2'd3, 1'b0, t, 1'b0, 32'h0); endtask

  function automatic void reset_chk(input string tag);
    chk({tag, "_pc"}, 64'(pc), 64'(RST_PC));
    chk({tag, "_ir"}, 64'({ir, opcode, funct}), 64'h0);
    chk({tag, "_cnt_err"}, 64'({instr_cnt, addr_err}), 64'h0);
  endfunction

  // Asynchronous reset asserted mid-cycle, discarding the pending fetch.
  task automatic reset_mid(input string tag);
    #1;
    rst_n = 1'b0;
    comb_q.delete();
    state_q.delete();
    model_reset();
    #1;
    reset_chk({tag, "_async"});
    @(posedge clk); @(negedge clk); #1;
    reset_chk({tag, "_hold"});
    pc_wr = 1'b0; ir_wr = 1'b0; force_en = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin : drive
    logic [31:0] w;
    int unsigned k;
    model_reset();
    repeat (3) @(negedge clk);
    reset_chk("por");
    #1 rst_n = 1'b1;

    // Reset state, then first fetch from RESET_PC with pc_wr low.
    step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) seq_step();                                  // pc 0x3010

    // beq imm16=FFFE from 0x3010, taken and not taken.
    load({6'b000100, 5'd1, 5'd2, 16'hFFFE});
    step(1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 1'b0, 32'h0);       // 0x300C
    jump_reg(32'h0000_3010);
    step(1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0, 32'h0);       // 0x3014

    // j target 26'h0000C10 from 0x3020.
    jump_reg(32'h0000_3020);
    load({6'b000010, 26'h0000C10});
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0);       // 0x3040

    // Misaligned jr sets the sticky flag.
    step(1'b1, 1'b1, 2'd3, 1'b0, 32'h0000_3006, 1'b0, 32'h0);
    repeat (3) seq_step();

    // PC wrap at the top of the address space.
    jump_reg(32'hFFFF_FFFC);
    seq_step();

    // bgezal rs_data=5 imm16=4 from 0x3000, then reset mid-instruction.
    jump_reg(32'h0000_3000);
    load({6'b000001, 5'd3, 5'b10001, 16'd4});
    step(1'b1, 1'b1, 2'd1, 1'b0, 32'd5, 1'b0, 32'h0);
    seq_step();
    reset_mid("mid");
    step(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Randomized controller traffic.
    for (int i = 0; i < 500; i++) begin
      bit fe;
      bit pw, iw;
      logic [31:0] rsd;
      fe = ($urandom_range(0, 3) == 0);
      k  = $urandom_range(0, 3);
      w  = $urandom;
      case (k)
        0: w = {6'b000100, w[25:0]};
        1: w = {6'b000001, w[25:21], ($urandom_range(0, 1) == 1) ? 5'b10001 : w[20:16], w[15:0]};
        2: w = {6'b000010, w[25:0]};
        default: ;
      endcase
      k = $urandom_range(0, 9);
      pw = (k < 7) || (k == 8);
      iw = (k < 8);
      rsd = $urandom;
      if ($urandom_range(0, 4) != 0) rsd = rsd & ~32'd3;
      step(pw, iw, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rsd, fe, w);
      if ($urandom_range(0, 99) == 0) begin
        reset_mid("rnd");
        step(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      end
    end

    // Idle edges so every queued expectation falls due.
    step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    chk("drain", 64'(comb_q.size() + state_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multicycle MIPS core, directly upstream of the main controller. Holds PC and IR, computes the next PC from the controller's `npc_sel`, loads a new instruction on `IRWr`, and feeds `opcode`/`funct` and the other IR fields back to the controller and datapath. It also keeps a retired-instruction counter and a sticky alignment-error flag.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_wr`  in  1  controller `PC_change_flag`: PC loads NPC this cycle.
- `ir_wr`  in  1  controller `IRWr`: IR loads `imem_rdata` this cycle.
- `npc_sel`  in  2  00 PC+4, 01 branch, 10 j/jal, 11 jr.
- `zero`  in  1  ALU zero flag for beq.
- `rs_data`  in  32  GPR[rs]; jr target and bgezal test.
- `imem_addr`  out  32  instruction ROM byte address (combinational).
- `imem_rdata`  in  32  instruction ROM data (asynchronous read).
- `pc`  out  32  current instruction address.
- `pc_plus4`  out  32  `pc + 4`; jal link value.
- `ir`  out  32  instruction register.
- `opcode`  out  6  `ir[31:26]`.
- `funct`  out  6  `ir[5:0]`.
- `rs`, `rt`, `rd`  out  5 each  `ir[25:21]`, `ir[20:16]`, `ir[15:11]`.
- `imm16`  out  16  `ir[15:0]`.
- `instr_cnt`  out  CNT_W  number of PC updates since reset.
- `addr_err`  out  1  sticky misaligned-jr flag.

## Operation
- PC always holds the address of the instruction in IR. NPC is computed from PC and the IR fields of that instruction:
  - 00: `pc + 4`.
  - 01: `pc + 4 + (sext(imm16) << 2)` if `br_cond`, else `pc + 4`.
    - `br_cond = zero` for beq (opcode 000100).
    - See Configuration for the bgezal case.
    - For any other opcode, `br_cond = 0`.
  - 10: `{pc_plus4[31:28], ir[25:0], 2'b00}`.
  - 11: `{rs_data[31:2], 2'b00}`.
- `imem_addr = pc_wr ? npc : pc`. With `pc_wr` high, the new PC and the instruction at that address load in the same edge. With `pc_wr` low (first fetch after reset), IR loads `imem[pc]`.
- When `pc_wr` is high:
  - `pc <= npc`.
  - `instr_cnt <= instr_cnt + 1`, wrapping modulo 2^CNT_W.
- When `ir_wr` is high: `ir <= imem_rdata`. When low, IR holds.
- `pc_wr` high with `ir_wr` low: PC updates and IR holds. Legal, but the controller never does this.
- `addr_err` sets when `pc_wr` is high, `npc_sel==11` and `rs_data[1:0]!=0`. It clears only on reset. The PC still loads the low-bit-cleared target.
- All 32-bit additions are modulo 2^32: `32'hFFFF_FFFC + 4 = 0`. Branches wrap the same way.

## Timing
- Reset (asynchronous, immediate on `rst_n` low): `pc=RESET_PC`, `ir=0` (sll nop, opcode/funct 0), `instr_cnt=0`, `addr_err=0`.
  - Reset mid-instruction discards the fetch in progress.
  - First rising edge after release with `ir_wr=1` loads `imem[RESET_PC]`.
- The controller holds IF for one cycle: `ir_wr` and `pc_wr` are single-cycle pulses. There is no handshake; the ROM must return data in the same cycle.
- Combinational paths: `imem_addr`, `pc_plus4` and the IR field outputs.
- Register latency: PC and IR change one edge after `pc_wr`/`ir_wr` is sampled. `opcode`/`funct` are valid to the controller from the cycle after IF through the end of the instruction.
- `npc_sel`, `zero`, `rs_data` must be stable in the `pc_wr` cycle. They are sampled only at that edge.

## Configuration
- `FETCH_BGEZAL_EN`:
  - Defined: branch select also resolves bgezal (opcode 000001, `rt==5'b10001`) with `br_cond = ~rs_data[31]`.
  - Undefined: that encoding gives `br_cond = 0`, so npc is `pc + 4`. All other behaviour is identical.

## Test plan
- Reset then first fetch: release `rst_n`, `ir_wr=1`, `pc_wr=0`.
  - `imem_addr=32'h3000`, IR loads `imem[0x3000]`, `pc` stays 0x3000, `instr_cnt=0`.
- Sequential: `npc_sel=00` with `pc_wr` and `ir_wr` pulsed together.
  - `pc` 0x3000→0x3004, IR loads `imem[0x3004]`, `instr_cnt=1`.
- beq with IR = beq with `imm16=16'hFFFE`, `pc=0x3010`:
  - `zero=1`: `pc` becomes 0x300C.
  - `zero=0`: `pc` becomes 0x3014.
- j with `ir[25:0]=26'h0000C10`, `pc=0x3020`: `pc` becomes 0x0000_3040.
- jr with `rs_data=32'h0000_3006`: `pc=0x3004`, `addr_err=1` and stays 1 until `rst_n` low.
- bgezal with `rs_data=5`, `imm16=4`, `pc=0x3000`:
  - `FETCH_BGEZAL_EN` defined: `pc` becomes 0x3014.
  - Undefined: `pc` becomes 0x3004.
  - Also assert `rst_n` low mid-sequence: all outputs return to reset values immediately.
